cv32e41s_alu_seq: RTL and testbench

//  Parametrised multi-cycle ALU for the bit-manipulation datapath: XLEN-wide add/sub, logic, shifts/rotates,
//  CLZ/CTZ/CPOP, and iterative carry-less multiply (CLMUL/CLMULH/CLMULR) at CLMUL_STEP bits/cycle.

---
 rtl/cv32e41s_alu_seq.sv | 186 ++++++++++++++++++
 tb/tb_cv32e41s_alu_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e41s_alu_seq.sv
// Multi-cycle bit-manipulation ALU with valid/ready handshakes and kill support.
// Single-cycle ops register their result; CLMUL* iterate CLMUL_STEP bits of operand b per cycle.
module cv32e41s_alu_seq #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned CLMUL_STEP = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            kill_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [3:0]      op_i,
   input  logic [XLEN-1:0] operand_a_i,
   input  logic [XLEN-1:0] operand_b_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);

   localparam int unsigned SW    = $clog2(XLEN);
   localparam int unsigned BCW   = SW + 1;
   localparam int unsigned NSTEP = XLEN / CLMUL_STEP;
   localparam int unsigned CNTW  = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
   typedef enum logic [3:0] {
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSra,
      OpRol, OpRor, OpClz, OpCtz, OpCpop, OpClmul, OpClmulh, OpClmulr
   } op_e;

   state_e            state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [2*XLEN-1:0] a_sh_q, a_sh_d;
   logic [XLEN-1:0]   b_q, b_d;
   op_e               op_q, op_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;

   op_e               op_in;
   logic              accept;
   logic              is_clmul;
   logic [SW-1:0]     shamt;
   logic [2*XLEN-1:0] rol_dbl, ror_dbl;
   logic [BCW-1:0]    clz, ctz, cpop;
   logic [XLEN-1:0]   alu_res;
   logic [2*XLEN-1:0] acc_step;
   logic [XLEN-1:0]   clmul_res;

   assign op_in    = op_e'(op_i);
   assign is_clmul = op_in inside {OpClmul, OpClmulh, OpClmulr};
   assign shamt    = operand_b_i[SW-1:0];
   // Rotates via a doubled operand avoid a special case for shamt == 0.
   assign rol_dbl  = {operand_a_i, operand_a_i} << shamt;
   assign ror_dbl  = {operand_a_i, operand_a_i} >> shamt;

   assign in_ready_o = !rst && !kill_i &&
                       ((state_q == StIdle) || ((state_q == StDone) && out_ready_i));
   assign accept     = in_valid_i && in_ready_o;

   always_comb begin
      clz  = BCW'(XLEN);
      ctz  = BCW'(XLEN);
      cpop = '0;
      for (int i = 0; i < XLEN; i++) begin
         if (operand_a_i[i]) clz = BCW'(XLEN - 1 - i);
         cpop = cpop + BCW'(operand_a_i[i]);
      end
      for (int i = XLEN - 1; i >= 0; i--) begin
         if (operand_a_i[i]) ctz = BCW'(i);
      end
   end

   always_comb begin
      alu_res = '0;
      case (op_in)
         OpAdd:   alu_res = operand_a_i + operand_b_i;
         OpSub:   alu_res = operand_a_i - operand_b_i;
         OpAnd:   alu_res = operand_a_i & operand_b_i;
         OpOr:    alu_res = operand_a_i | operand_b_i;
         OpXor:   alu_res = operand_a_i ^ operand_b_i;
         OpSll:   alu_res = operand_a_i << shamt;
         OpSrl:   alu_res = operand_a_i >> shamt;
         OpSra:   alu_res = $unsigned($signed(operand_a_i) >>> shamt);
         OpRol:   alu_res = rol_dbl[2*XLEN-1:XLEN];
         OpRor:   alu_res = ror_dbl[XLEN-1:0];
         OpClz:   alu_res = {{(XLEN-BCW){1'b0}}, clz};
         OpCtz:   alu_res = {{(XLEN-BCW){1'b0}}, ctz};
         OpCpop:  alu_res = {{(XLEN-BCW){1'b0}}, cpop};
         default: alu_res = '0;
      endcase
   end

   // a_sh_q/b_q are pre-shifted each cycle so the step only looks at the low bits of b.
   always_comb begin
      acc_step = acc_q;
      for (int j = 0; j < CLMUL_STEP; j++) begin
         if (b_q[j]) acc_step = acc_step ^ (a_sh_q << j);
      end
      case (op_q)
         OpClmulh: clmul_res = acc_step[2*XLEN-1:XLEN];
         OpClmulr: clmul_res = acc_step[2*XLEN-2:XLEN-1];
         default:  clmul_res = acc_step[XLEN-1:0];
      endcase
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      acc_d       = acc_q;
      a_sh_d      = a_sh_q;
      b_d         = b_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      if (kill_i) begin
         state_d     = StIdle;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            StBusy: begin
               acc_d  = acc_step;
               a_sh_d = a_sh_q << CLMUL_STEP;
               b_d    = b_q >> CLMUL_STEP;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CNTW'(NSTEP - 1)) begin
                  state_d     = StDone;
                  out_valid_d = 1'b1;
                  result_d    = clmul_res;
               end
            end
            StDone: begin
               if (out_ready_i) begin
                  state_d     = StIdle;
                  out_valid_d = 1'b0;
               end
            end
            default: state_d = StIdle;
         endcase
         // Accept overrides the drain above, giving zero-bubble back-to-back operation.
         if (accept) begin
            if (is_clmul) begin
               state_d     = StBusy;
               out_valid_d = 1'b0;
               acc_d       = '0;
               cnt_d       = '0;
               a_sh_d      = {{XLEN{1'b0}}, operand_a_i};
               b_d         = operand_b_i;
               op_d        = op_in;
            end else begin
               state_d     = StDone;
               out_valid_d = 1'b1;
               result_d    = alu_res;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         acc_q       <= '0;
         a_sh_q      <= '0;
         b_q         <= '0;
         op_q        <= OpAdd;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         acc_q       <= acc_d;
         a_sh_q      <= a_sh_d;
         b_q         <= b_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign result_o    = result_q;
   assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_cv32e41s_alu_seq.sv
// Directed bench for cv32e41s_alu_seq: 32-bit/STEP=4 instance plus a 64-bit/STEP=1 instance.
module tb_cv32e41s_alu_seq;

   localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  AND = 4'd2,  OR = 4'd3,  XOR = 4'd4;
   localparam logic [3:0] SLL = 4'd5,  SRL = 4'd6,  SRA = 4'd7,  ROL = 4'd8,  ROR = 4'd9;
   localparam logic [3:0] CLZ = 4'd10, CTZ = 4'd11, CPOP = 4'd12;
   localparam logic [3:0] CLMUL = 4'd13, CLMULH = 4'd14, CLMULR = 4'd15;

   localparam int NALU = 17;
   localparam logic [3:0] AOP [NALU] = '{ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, ROL, ROR, ROL,
                                         CLZ, CLZ, CTZ, CTZ, CPOP, SRA};
   localparam logic [31:0] AA [NALU] = '{32'hFFFFFFFF, 32'h0, 32'hF0F01234, 32'hF0000000,
                                        32'hAAAA5555, 32'h1, 32'h80000000, 32'h80000000,
                                        32'h80000001, 32'h1, 32'h12345678, 32'h0, 32'h00010000,
                                        32'h00010000, 32'h0, 32'h0000F0F0, 32'h40000000};
   localparam logic [31:0] AB [NALU] = '{32'h1, 32'h1, 32'h0FF0FFFF, 32'h0000000F,
                                        32'hFFFF0000, 32'h21, 32'h1F, 32'h24, 32'h4, 32'h1,
                                        32'h20, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1F};
   localparam logic [31:0] AE [NALU] = '{32'h0, 32'hFFFFFFFF, 32'h00F01234, 32'hF000000F,
                                        32'h55555555, 32'h2, 32'h1, 32'hF8000000, 32'h18,
                                        32'h80000000, 32'h12345678, 32'd32, 32'd15, 32'd16,
                                        32'd32, 32'd8, 32'h0};

   localparam int NCL = 5;
   localparam logic [3:0]  COP [NCL] = '{CLMUL, CLMULH, CLMULR, CLMULH, CLMUL};
   localparam logic [31:0] CA [NCL] = '{32'h3, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                                       32'hFFFFFFFF};
   localparam logic [31:0] CB [NCL] = '{32'h3, 32'h2, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF};
   localparam logic [31:0] CE [NCL] = '{32'h5, 32'h1, 32'h1, 32'h55555555, 32'h55555555};

   logic        clk = 1'b0;
   logic        rst, kill_i;
   logic        in_valid, out_ready, in_ready, out_valid, busy;
   logic [3:0]  op;
   logic [31:0] a, b, result;
   logic        in_valid64, out_ready64, in_ready64, out_valid64, busy64;
   logic [63:0] a64, b64, result64;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cv32e41s_alu_seq #(.XLEN(32), .CLMUL_STEP(4)) u_dut (
      .clk(clk), .rst(rst), .kill_i(kill_i), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .op_i(op), .operand_a_i(a), .operand_b_i(b), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .result_o(result), .busy_o(busy)
   );

   cv32e41s_alu_seq #(.XLEN(64), .CLMUL_STEP(1)) u_dut64 (
      .clk(clk), .rst(rst), .kill_i(kill_i), .in_valid_i(in_valid64), .in_ready_o(in_ready64),
      .op_i(op), .operand_a_i(a64), .operand_b_i(b64), .out_valid_o(out_valid64),
      .out_ready_i(out_ready64), .result_o(result64), .busy_o(busy64)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; kill_i = 1'b0; in_valid = 1'b1; out_ready = 1'b1; op = ADD;
      a = 32'h5; b = 32'h6; in_valid64 = 1'b0; out_ready64 = 1'b1; a64 = '0; b64 = '0;
      tick(); tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
      checks++; if (in_ready64 !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready64: got %b want 1", in_ready64); end
   endtask

   task automatic test_alu();
      out_ready = 1'b1;
      for (int i = 0; i < NALU; i++) begin
         op = AOP[i]; a = AA[i]; b = AB[i]; in_valid = 1'b1;
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL alu%0d_in_ready: got %b want 1", i, in_ready); end
         tick();
         in_valid = 1'b0;
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL alu%0d_valid_t1: got %b want 1", i, out_valid); end
         checks++; if (result !== AE[i]) begin errors++; $display("FAIL alu%0d_result op %0d: got %h want %h", i, AOP[i], result, AE[i]); end
         tick();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL alu%0d_drain: got %b want 0", i, out_valid); end
      end
   endtask

   task automatic test_clmul();
      out_ready = 1'b1;
      for (int i = 0; i < NCL; i++) begin
         op = COP[i]; a = CA[i]; b = CB[i]; in_valid = 1'b1;
         tick();
         // Operands change after accept and must be ignored.
         in_valid = 1'b0; op = ADD; a = 32'hDEADBEEF; b = 32'h0;
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clmul%0d_busy: got %b want 1", i, busy); end
         repeat (7) tick();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clmul%0d_early_valid: got %b want 0", i, out_valid); end
         tick();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clmul%0d_valid_t9: got %b want 1", i, out_valid); end
         checks++; if (result !== CE[i]) begin errors++; $display("FAIL clmul%0d_result: got %h want %h", i, result, CE[i]); end
         tick();
      end
   endtask

   task automatic test_stall();
      out_ready = 1'b0; op = ADD; a = 32'd5; b = 32'd7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (result !== 32'd12) begin errors++; $display("FAIL stall_first: got %h want c", result); end
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; op = SUB; a = 32'hFF; b = 32'h1;
         #1;
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall%0d_in_ready: got %b want 0", k, in_ready); end
         tick();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall%0d_valid: got %b want 1", k, out_valid); end
         checks++; if (result !== 32'd12) begin errors++; $display("FAIL stall%0d_result: got %h want c", k, result); end
      end
      op = ADD; a = 32'd1; b = 32'd1; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || result !== 32'd2) begin errors++; $display("FAIL stall_b2b: got %b/%h want 1/2", out_valid, result); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_kill();
      int seen;
      out_ready = 1'b1; op = CLMUL; a = 32'h3; b = 32'h3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      kill_i = 1'b1; in_valid = 1'b1; op = ADD; a = 32'd9; b = 32'd9;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL kill_beats_accept: got %b want 0", in_ready); end
      tick();
      kill_i = 1'b0; in_valid = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_busy: got %b want 0", busy); end
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         if (out_valid !== 1'b0) seen++;
         tick();
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL kill_no_pulse: got %0d valid cycles want 0", seen); end
      op = ADD; a = 32'd2; b = 32'd3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || result !== 32'd5) begin errors++; $display("FAIL kill_next_add: got %b/%h want 1/5", out_valid, result); end
      out_ready = 1'b0;
      kill_i = 1'b1;
      tick();
      kill_i = 1'b0; out_ready = 1'b1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL kill_in_done: got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      out_ready = 1'b1; op = ADD;
      for (int i = 0; i < 8; i++) begin
         a = 32'(i) * 32'h01010101; b = 32'h000000F0 + 32'(i); in_valid = 1'b1;
         exp = a + b;
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_in_ready: got %b want 1", i, in_ready); end
         tick();
         checks++; if (out_valid !== 1'b1 || result !== exp) begin errors++; $display("FAIL b2b%0d_result: got %b/%h want 1/%h", i, out_valid, result, exp); end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_rst_busy();
      out_ready = 1'b1; op = CLMUL; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_busy_in_ready: got %b want 0", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_busy_valid: got %b want 0", out_valid); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_busy_result: got %h want 0", result); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_busy: got %b want 0", busy); end
      rst = 1'b0;
      repeat (10) tick();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_busy_quiet: got %b/%b want 0/0", out_valid, busy); end
   endtask

   task automatic test_clmul64();
      out_ready64 = 1'b1; op = CLMULH; a64 = 64'h8000000000000000; b64 = 64'h2; in_valid64 = 1'b1;
      #1;
      checks++; if (in_ready64 !== 1'b1) begin errors++; $display("FAIL x64_in_ready: got %b want 1", in_ready64); end
      tick();
      in_valid64 = 1'b0; op = ADD;
      repeat (63) tick();
      checks++; if (out_valid64 !== 1'b0) begin errors++; $display("FAIL x64_clmulh_early: got %b want 0", out_valid64); end
      tick();
      checks++; if (out_valid64 !== 1'b1 || result64 !== 64'h1) begin errors++; $display("FAIL x64_clmulh: got %b/%h want 1/1", out_valid64, result64); end
      tick();
      op = CLMULR; a64 = 64'h8000000000000000; b64 = 64'h1; in_valid64 = 1'b1;
      tick();
      in_valid64 = 1'b0;
      repeat (64) tick();
      checks++; if (out_valid64 !== 1'b1 || result64 !== 64'h1) begin errors++; $display("FAIL x64_clmulr: got %b/%h want 1/1", out_valid64, result64); end
      tick();
      op = ADD; a64 = 64'hFFFFFFFFFFFFFFFF; b64 = 64'h1; in_valid64 = 1'b1;
      tick();
      in_valid64 = 1'b0;
      checks++; if (out_valid64 !== 1'b1 || result64 !== 64'h0) begin errors++; $display("FAIL x64_add: got %b/%h want 1/0", out_valid64, result64); end
      tick();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_clmul();
      test_stall();
      test_kill();
      test_back_to_back();
      test_rst_busy();
      test_clmul64();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
